// File: rtl/dino_pkg.sv
// Shared constants for the dino player front end: tick phase indices and default timing.
package dino_pkg;

  localparam int TICK_VEL = 0;
  localparam int TICK_POS = 1;

  localparam int DEFAULT_TICK_PERIOD     = 416667;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a hold-time debouncer for one raw button.
module button_debouncer
  import dino_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] count_q, count_d;

  // The counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    sync_d   = {sync_q[0], raw};
    stable_d = stable_q;
    count_d  = '0;
    if (sync_q[1] != stable_q) begin
      if (count_q == COUNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      count_q  <= count_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/player_input_conditioner.sv
// Debounced, frame-frozen button levels plus the two-phase game_tick strobe.
// Define STICKY_JUMP_EN to latch short up taps until the next frame load.
module player_input_conditioner
  import dino_pkg::*;
#(
  parameter int TICK_PERIOD     = DEFAULT_TICK_PERIOD,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  output logic [1:0] game_tick,
  output logic       button_up,
  output logic       button_down
);

  localparam int TW = $clog2(TICK_PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
  localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_PERIOD - 2);

  logic          stable_up, stable_down;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    tick_q, tick_d;
  logic          button_up_q, button_up_d;
  logic          button_down_q, button_down_d;
  logic          load;
  logic          up_level;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_debouncer (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_up_raw),
    .stable (stable_up)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_debouncer (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_down_raw),
    .stable (stable_down)
  );

  assign load = (tick_cnt_q == TICK_LOAD);

`ifdef STICKY_JUMP_EN
  logic jump_q, jump_d;
  logic up_prev_q;
  logic up_rise;

  // A rise landing in the load cycle is kept for the following frame.
  always_comb begin
    up_rise  = stable_up & ~up_prev_q;
    up_level = stable_up | jump_q;
    jump_d   = load ? up_rise : (jump_q | up_rise);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jump_q    <= 1'b0;
      up_prev_q <= 1'b0;
    end else begin
      jump_q    <= jump_d;
      up_prev_q <= stable_up;
    end
  end
`else
  always_comb begin
    up_level = stable_up;
  end
`endif

  // Buttons load together with the velocity strobe so both phases see the same frame.
  always_comb begin
    tick_cnt_d       = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
    tick_d           = '0;
    tick_d[TICK_VEL] = load;
    tick_d[TICK_POS] = tick_q[TICK_VEL];
    button_up_d      = button_up_q;
    button_down_d    = button_down_q;
    if (load) begin
      button_up_d   = up_level;
      button_down_d = stable_down & ~up_level;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q    <= '0;
      tick_q        <= '0;
      button_up_q   <= 1'b0;
      button_down_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      tick_q        <= tick_d;
      button_up_q   <= button_up_d;
      button_down_q <= button_down_d;
    end
  end

  assign game_tick   = tick_q;
  assign button_up   = button_up_q;
  assign button_down = button_down_q;

endmodule

// File: tb/tb_player_input_conditioner.sv
// Scoreboard bench for player_input_conditioner with TICK_PERIOD=8, DEBOUNCE_CYCLES=4.
// Cycle 1 is the clock period right after the last reset edge; game_tick[0] is due at cycles 8, 16, 24.
module tb_player_input_conditioner;

  localparam int TP = 8;
  localparam int DC = 4;
`ifdef STICKY_JUMP_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    int         cyc;
    int         kind;
    logic [1:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up_raw = 1'b0;
  logic       btn_down_raw = 1'b0;
  logic [1:0] game_tick;
  logic       button_up;
  logic       button_down;

  exp_t sb[$];
  int   cyc = 1;
  int   assertCount = 0;
  int   failCount = 0;

  player_input_conditioner #(.TICK_PERIOD(TP), .DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .game_tick    (game_tick),
    .button_up    (button_up),
    .button_down  (button_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 1;
    else       cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input int cycle,
                             input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, observed, expected);
    end
  endtask

  function automatic logic [1:0] tickModel(input int c);
    if (c >= TP && (c % TP) == 0)    return 2'b01;
    else if (c > TP && (c % TP) == 1) return 2'b10;
    else                              return 2'b00;
  endfunction

  task automatic expectTicks(input int first, input int last);
    for (int c = first; c <= last; c++) sb.push_back('{c, 0, tickModel(c)});
  endtask

  task automatic expectButtons(input int first, input int last, input logic up, input logic down);
    for (int c = first; c <= last; c++) begin
      sb.push_back('{c, 1, {1'b0, up}});
      sb.push_back('{c, 2, {1'b0, down}});
    end
  endtask

  // Pop every expectation due in the current cycle and compare it against the DUT.
  always @(negedge clk) begin
    int i;
    if (!reset) begin
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            0:       checkOutput("game_tick", cyc, {30'b0, game_tick}, {30'b0, sb[i].val});
            1:       checkOutput("button_up", cyc, {31'b0, button_up}, {30'b0, sb[i].val});
            default: checkOutput("button_down", cyc, {31'b0, button_down}, {30'b0, sb[i].val});
          endcase
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic drainScoreboard();
    checkOutput("sb_drain", cyc, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic goToCycle(input int c);
    for (int i = 0; i < 200 && cyc != c; i++) begin
      @(posedge clk);
      #2;
    end
    if (cyc != c) checkOutput("goto_timeout", c, 32'(cyc), 32'(c));
  endtask

  task automatic applyReset(input logic up, input logic down);
    @(posedge clk);
    #2;
    reset = 1'b1;
    btn_up_raw = up;
    btn_down_raw = down;
    drainScoreboard();
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int c, input logic up, input logic down);
    goToCycle(c);
    btn_up_raw = up;
    btn_down_raw = down;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] start, sticky jump %0d", STICKY);

    // Idle frames: strobes only.
    applyReset(1'b0, 1'b0);
    expectTicks(1, 26);
    expectButtons(1, 26, 1'b0, 1'b0);
    goToCycle(27);

    // Up held through reset: stable after edge 6, first load visible in cycle 8.
    applyReset(1'b1, 1'b0);
    expectTicks(1, 17);
    expectButtons(1, 7, 1'b0, 1'b0);
    expectButtons(8, 17, 1'b1, 1'b0);
    goToCycle(18);

    // Three-cycle glitch never gets accepted.
    applyReset(1'b0, 1'b0);
    expectTicks(1, 26);
    expectButtons(1, 26, 1'b0, 1'b0);
    applyStimulus(3, 1'b1, 1'b0);
    applyStimulus(6, 1'b0, 1'b0);
    goToCycle(27);

    // Six-cycle tap: debounced level is high for cycles 9..14 only, between the loads.
    applyReset(1'b0, 1'b0);
    expectTicks(1, 26);
    if (STICKY) begin
      expectButtons(1, 15, 1'b0, 1'b0);
      expectButtons(16, 23, 1'b1, 1'b0);
      expectButtons(24, 26, 1'b0, 1'b0);
    end else begin
      expectButtons(1, 26, 1'b0, 1'b0);
    end
    applyStimulus(3, 1'b1, 1'b0);
    applyStimulus(9, 1'b0, 1'b0);
    goToCycle(27);

    // Both held: jump wins; up released in cycle 9 drops its stable level before the cycle-16 load.
    // With sticky jump, the rise that coincided with the first load carries one extra up frame.
    applyReset(1'b1, 1'b1);
    expectTicks(1, 26);
    expectButtons(1, 7, 1'b0, 1'b0);
    expectButtons(8, 15, 1'b1, 1'b0);
    if (STICKY) expectButtons(16, 23, 1'b1, 1'b0);
    else        expectButtons(16, 23, 1'b0, 1'b1);
    expectButtons(24, 26, 1'b0, 1'b1);
    applyStimulus(9, 1'b0, 1'b1);
    goToCycle(27);

    // Reset mid-frame with button_up high, then a fresh frame timeline.
    applyReset(1'b1, 1'b0);
    expectTicks(1, 11);
    expectButtons(1, 7, 1'b0, 1'b0);
    expectButtons(8, 11, 1'b1, 1'b0);
    goToCycle(12);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_game_tick", cyc, {30'b0, game_tick}, 32'd0);
    checkOutput("rst_button_up", cyc, {31'b0, button_up}, 32'd0);
    checkOutput("rst_button_down", cyc, {31'b0, button_down}, 32'd0);
    drainScoreboard();
    @(posedge clk);
    #2;
    reset = 1'b0;
    expectTicks(1, 17);
    expectButtons(1, 7, 1'b0, 1'b0);
    expectButtons(8, 17, 1'b1, 1'b0);
    goToCycle(18);

    @(posedge clk);
    #2;
    drainScoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
